// File: rtl/if_fetch_queue_if.sv
// Handshake bundle between the PC/ROM stage, the fetch queue and decode.
// The slave side is the queue itself; the master side drives fetch/decode stimulus.
interface if_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] pc_i;
  logic          ce_i;
  logic [DW-1:0] inst_i;
  logic          flush_i;
  logic          id_ready_i;
  logic          id_valid_o;
  logic [AW-1:0] id_pc_o;
  logic [DW-1:0] id_inst_o;
  logic          stall_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  pc_i, ce_i, inst_i, flush_i, id_ready_i,
    output id_valid_o, id_pc_o, id_inst_o, stall_o, count_o
  );

  modport master (
    output pc_i, ce_i, inst_i, flush_i, id_ready_i,
    input  id_valid_o, id_pc_o, id_inst_o, stall_o, count_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Circular {pc, inst} buffer between fetch and decode: stalls fetch when full,
// presents the oldest pair to decode, and empties itself on a pipeline flush.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic            clk,
  input logic            rst,
  if_fetch_queue_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] pc_mem_q   [DEPTH];
  logic [DW-1:0] inst_mem_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // A push while full is refused even if a pop frees a slot this cycle.
  assign push = fq.ce_i & ~full & ~fq.flush_i;
  assign pop  = fq.id_ready_i & ~empty & ~fq.flush_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (fq.flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is not reset; empty entries are masked by cnt, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wp_q]   <= fq.pc_i;
      inst_mem_q[wp_q] <= fq.inst_i;
    end
  end

  assign fq.id_valid_o = ~empty;
  assign fq.id_pc_o    = empty ? '0 : pc_mem_q[rp_q];
  assign fq.id_inst_o  = empty ? '0 : inst_mem_q[rp_q];
  assign fq.stall_o    = full;
  assign fq.count_o    = cnt_q;
endmodule
